// File: rtl/gshare_predictor.sv
// Parametrised gshare direction predictor: PC xor speculative global history indexes
// a table of saturating counters; separate lookup and late-resolution update ports.
module gshare_predictor #(
    parameter int INDEX_BITS = 8,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 8,
    parameter int CTR_INIT   = 1,
    parameter int STAT_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ready,
    input  logic                  pred_valid,
    input  logic [31:0]           pred_pc,
    output logic                  pred_resp_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    output logic [HIST_BITS-1:0]  pred_hist,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic [HIST_BITS-1:0]  upd_hist,
    input  logic                  upd_taken,
    input  logic                  upd_mispred,
    input  logic                  clear_stats,
    output logic [STAT_BITS-1:0]  branch_count,
    output logic [STAT_BITS-1:0]  mispred_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                state, state_next;
    logic [INDEX_BITS-1:0] ptr;
    logic [HIST_BITS-1:0]  ghr, ghr_next;
    logic [CTR_BITS-1:0]   table_q [ENTRIES];

    logic                  run;
    logic                  lookup_fire;
    logic                  upd_fire;
    logic [INDEX_BITS-1:0] lookup_idx;
    logic [CTR_BITS-1:0]   lookup_ctr;
    logic [CTR_BITS-1:0]   ctr_cur;
    logic [CTR_BITS-1:0]   ctr_new;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0]};

    assign run         = (state == S_RUN);
    assign ready       = run;
    assign lookup_fire = run && pred_valid;
    assign upd_fire    = run && upd_valid;
    assign lookup_idx  = pred_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
    assign lookup_ctr  = table_q[lookup_idx];
    assign ctr_cur     = table_q[upd_index];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (state == S_INIT)
                ptr <= ptr + INDEX_BITS'(1);
        end
    end

    always_comb begin
        state_next = state;
        if (state == S_INIT && ptr == '1)
            state_next = S_RUN;
    end

    // The {hist, bit} concatenation truncated to HIST_BITS also covers HIST_BITS == 1.
    always_comb begin
        ghr_next = ghr;
        if (lookup_fire)
            ghr_next = HIST_BITS'({ghr, lookup_ctr[CTR_BITS-1]});
        if (upd_fire && upd_mispred)
            ghr_next = HIST_BITS'({upd_hist, upd_taken});
    end

    always_comb begin
        ctr_new = ctr_cur;
        if (upd_taken && ctr_cur != '1)
            ctr_new = ctr_cur + CTR_BITS'(1);
        else if (!upd_taken && ctr_cur != '0)
            ctr_new = ctr_cur - CTR_BITS'(1);
    end

    // Table is not reset; the INIT sweep rewrites every entry after each reset.
    always_ff @(posedge clk) begin
        if (state == S_INIT)
            table_q[ptr] <= CTR_BITS'(CTR_INIT);
        else if (upd_fire)
            table_q[upd_index] <= ctr_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr             <= '0;
            pred_resp_valid <= 1'b0;
            pred_taken      <= 1'b0;
            pred_index      <= '0;
            pred_hist       <= '0;
        end else begin
            ghr             <= ghr_next;
            pred_resp_valid <= lookup_fire;
            if (lookup_fire) begin
                pred_taken <= lookup_ctr[CTR_BITS-1];
                pred_index <= lookup_idx;
                pred_hist  <= ghr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count  <= '0;
            mispred_count <= '0;
        end else if (run) begin
            if (clear_stats) begin
                branch_count  <= '0;
                mispred_count <= '0;
            end else if (upd_valid) begin
                if (branch_count != '1)
                    branch_count <= branch_count + STAT_BITS'(1);
                if (upd_mispred && mispred_count != '1)
                    mispred_count <= mispred_count + STAT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor with a reference model and a response scoreboard.
module tb_gshare_predictor;

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_resp_valid;
    logic        pred_taken;
    logic [7:0]  pred_index;
    logic [7:0]  pred_hist;
    logic        upd_valid;
    logic [7:0]  upd_index;
    logic [7:0]  upd_hist;
    logic        upd_taken;
    logic        upd_mispred;
    logic        clear_stats;
    logic [3:0]  branch_count;
    logic [3:0]  mispred_count;

    gshare_predictor #(
        .INDEX_BITS(8),
        .CTR_BITS  (2),
        .HIST_BITS (8),
        .CTR_INIT  (1),
        .STAT_BITS (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ready          (ready),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_resp_valid(pred_resp_valid),
        .pred_taken     (pred_taken),
        .pred_index     (pred_index),
        .pred_hist      (pred_hist),
        .upd_valid      (upd_valid),
        .upd_index      (upd_index),
        .upd_hist       (upd_hist),
        .upd_taken      (upd_taken),
        .upd_mispred    (upd_mispred),
        .clear_stats    (clear_stats),
        .branch_count   (branch_count),
        .mispred_count  (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model
    logic [1:0]  tbl_m [256];
    logic [7:0]  ghr_m;
    logic        run_m;
    logic [7:0]  ptr_m;
    logic [3:0]  bc_m;
    logic [3:0]  mc_m;
    logic [16:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) tbl_m[i] = 2'd1;
        ghr_m = 8'h00;
        run_m = 1'b0;
        ptr_m = 8'h00;
        bc_m  = 4'd0;
        mc_m  = 4'd0;
        sb.delete();
    endtask

    function automatic logic [31:0] pc_for(input logic [7:0] idx);
        return {22'd0, idx ^ ghr_m, 2'b00};
    endfunction

    task automatic cyc(input logic pv, input logic [31:0] pc, input logic uv,
                       input logic [7:0] ui, input logic [7:0] uh, input logic ut,
                       input logic um, input logic cs);
        logic       exp_valid;
        logic [7:0] idx;
        logic [7:0] ghr_n;
        logic [16:0] ent;
        pred_valid  = pv;
        pred_pc     = pc;
        upd_valid   = uv;
        upd_index   = ui;
        upd_hist    = uh;
        upd_taken   = ut;
        upd_mispred = um;
        clear_stats = cs;
        exp_valid = run_m && pv;
        ghr_n = ghr_m;
        if (exp_valid) begin
            idx = pc[9:2] ^ ghr_m;
            sb.push_back({tbl_m[idx][1], idx, ghr_m});
            ghr_n = {ghr_m[6:0], tbl_m[idx][1]};
        end
        if (run_m) begin
            if (uv) begin
                if (ut && tbl_m[ui] != 2'd3) tbl_m[ui] = tbl_m[ui] + 2'd1;
                else if (!ut && tbl_m[ui] != 2'd0) tbl_m[ui] = tbl_m[ui] - 2'd1;
                if (um) ghr_n = {uh[6:0], ut};
            end
            if (cs) begin
                bc_m = 4'd0;
                mc_m = 4'd0;
            end else if (uv) begin
                if (bc_m != 4'hF) bc_m = bc_m + 4'd1;
                if (um && mc_m != 4'hF) mc_m = mc_m + 4'd1;
            end
            ghr_m = ghr_n;
        end else begin
            if (ptr_m == 8'hFF) run_m = 1'b1;
            else ptr_m = ptr_m + 8'd1;
        end
        @(posedge clk);
        #1;
        chk("ready", ready, run_m);
        chk("resp_valid", pred_resp_valid, exp_valid);
        if (exp_valid && sb.size() > 0) begin
            ent = sb.pop_front();
            chk("pred_taken", pred_taken, ent[16]);
            chk("pred_index", pred_index, ent[15:8]);
            chk("pred_hist", pred_hist, ent[7:0]);
        end
        chk("branch_count", branch_count, bc_m);
        chk("mispred_count", mispred_count, mc_m);
    endtask

    task automatic lookup(input logic [31:0] pc);
        cyc(1'b1, pc, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [7:0] ui, input logic ut, input logic um);
        cyc(1'b0, 32'd0, 1'b1, ui, 8'h00, ut, um, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        pred_valid = 1'b0; pred_pc = '0; upd_valid = 1'b0; upd_index = '0;
        upd_hist = '0; upd_taken = 1'b0; upd_mispred = 1'b0; clear_stats = 1'b0;
        model_reset();
        #12;
        chk("rst_ready", ready, 1'b0);
        chk("rst_resp_valid", pred_resp_valid, 1'b0);
        chk("rst_pred", {pred_taken, pred_index, pred_hist}, 17'd0);
        chk("rst_counts", {branch_count, mispred_count}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // init sweep: requests ignored, ready after exactly 256 edges
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 32'h40, 1'b1, 8'h10, 8'h00, 1'b1, 1'b1, 1'b1);
            if (i == 254) chk("ready_at_255", ready, 1'b0);
        end
        chk("ready_at_256", ready, 1'b1);
        chk("init_counts", {branch_count, mispred_count}, 8'd0);

        lookup(32'h40);
        chk("first_taken", pred_taken, 1'b0);
        chk("first_index", pred_index, 8'h10);
        chk("first_hist", pred_hist, 8'h00);

        // training and speculative history
        update(8'h10, 1'b1, 1'b0);
        update(8'h10, 1'b1, 1'b0);
        lookup(32'h40);
        chk("trained_taken", pred_taken, 1'b1);
        lookup(32'h40);
        chk("spec_index", pred_index, 8'h11);
        chk("spec_hist", pred_hist, 8'h01);

        // saturation at 11 and 00
        for (int i = 0; i < 5; i++) update(8'h10, 1'b1, 1'b0);
        update(8'h10, 1'b0, 1'b0);
        lookup(pc_for(8'h10));
        chk("sat_hi_10", pred_taken, 1'b1);
        update(8'h10, 1'b0, 1'b0);
        lookup(pc_for(8'h10));
        chk("sat_hi_01", pred_taken, 1'b0);
        for (int i = 0; i < 4; i++) update(8'h10, 1'b0, 1'b0);
        update(8'h10, 1'b1, 1'b0);
        lookup(pc_for(8'h10));
        chk("sat_lo_01", pred_taken, 1'b0);

        // same-cycle lookup and update of one entry: read-before-write
        cyc(1'b1, pc_for(8'h30), 1'b1, 8'h30, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("rbw_old", pred_taken, 1'b0);
        lookup(pc_for(8'h30));
        chk("rbw_new", pred_taken, 1'b1);

        // mispredict repair with same-cycle lookup
        cyc(1'b0, 32'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clear_counts", {branch_count, mispred_count}, 8'd0);
        cyc(1'b1, 32'h40, 1'b1, 8'h20, 8'h5A, 1'b1, 1'b1, 1'b0);
        chk("repair_counts", {branch_count, mispred_count}, {4'd1, 4'd1});
        lookup(32'h0);
        chk("repair_hist", pred_hist, 8'hB5);
        chk("repair_index", pred_index, 8'hB5);

        // stats saturation and clear priority
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 32'd0, 1'b1, 8'(i), 8'(i * 7), 1'(i), 1'b1, 1'b0);
        chk("stat_sat", {branch_count, mispred_count}, 8'hFF);
        cyc(1'b1, 32'h80, 1'b1, 8'h44, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("clear_wins", {branch_count, mispred_count}, 8'h00);
        cyc(1'b1, 32'h84, 1'b1, 8'h45, 8'h00, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-run
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", ready, 1'b0);
        chk("midrst_resp_valid", pred_resp_valid, 1'b0);
        chk("midrst_counts", {branch_count, mispred_count}, 8'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++)
            cyc(1'b0, 32'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reinit_ready", ready, 1'b1);
        lookup(32'h40);
        chk("reinit_taken", pred_taken, 1'b0);
        chk("reinit_index", pred_index, 8'h10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised gshare branch direction predictor, next generation after the fixed 256-entry, 2-bit, PC-indexed predictor.
- Table depth, counter width and global-history length are configurable.
- Prediction and resolution are split into separate lookup and update ports, so the core can resolve branches late.
- Adds speculative global history with mispredict repair, a post-reset table-init sweep, and saturating statistics counters.

Parameters:
INDEX_BITS, 8, log2 of table entries (ENTRIES = 2**INDEX_BITS)
CTR_BITS, 2, saturating counter width (>=1); prediction = counter MSB
HIST_BITS, 8, global history length (1..INDEX_BITS)
CTR_INIT, 1, counter value written at init (weakly not-taken for CTR_BITS=2)
STAT_BITS, 16, width of branch/mispredict counters

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset
ready  out  1  high once init sweep complete
pred_valid  in  1  lookup request this cycle
pred_pc  in  32  PC of branch being looked up
pred_resp_valid  out  1  registered: response for previous-cycle lookup
pred_taken  out  1  registered predicted direction
pred_index  out  INDEX_BITS  registered table index used (returned later on update)
pred_hist  out  HIST_BITS  registered GHR value used for the index (pre-shift snapshot)
upd_valid  in  1  branch resolution
upd_index  in  INDEX_BITS  index from the matching lookup
upd_hist  in  HIST_BITS  history snapshot from the matching lookup
upd_taken  in  1  actual outcome
upd_mispred  in  1  resolved direction differed from prediction
clear_stats  in  1  synchronous clear of statistics
branch_count  out  STAT_BITS  resolved branches
mispred_count  out  STAT_BITS  mispredicted branches

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous, active-low.
- While rst_n is low:
  - state = INIT, sweep pointer 0, GHR 0.
  - ready, pred_resp_valid, pred_taken, pred_index, pred_hist, branch_count, mispred_count all 0.
- INIT state:
  - Starts after rst_n deasserts. Writes CTR_INIT to entry ptr each cycle, ptr increments.
  - After the write of entry ENTRIES-1, go to RUN. ready = 1 from the next cycle, exactly ENTRIES cycles after the first rising edge with rst_n high.
  - pred_valid, upd_valid and clear_stats are ignored in INIT; pred_resp_valid stays 0.
- Index: idx = pred_pc[INDEX_BITS+1:2] XOR zero-extended GHR.
- Lookup (RUN, pred_valid = 1):
  - Next cycle: pred_resp_valid = 1, pred_taken = table[idx] MSB, pred_index = idx, pred_hist = GHR.
  - pred_resp_valid = 0 in any cycle following no lookup; other response outputs hold their values.
- Speculative history: an accepted lookup shifts GHR <= {GHR[HIST_BITS-2:0], predicted bit}. For HIST_BITS=1, GHR <= predicted bit.
- Update (RUN, upd_valid = 1):
  - table[upd_index] moves +1 if upd_taken, -1 otherwise.
  - Saturates at 0 and 2**CTR_BITS-1.
- Mispredict repair (upd_valid and upd_mispred):
  - GHR <= {upd_hist[HIST_BITS-2:0], upd_taken}.
  - Overrides any same-cycle lookup shift.
  - A same-cycle lookup is still answered, using the pre-repair GHR for its index.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update counter (read-before-write).
- Stats:
  - branch_count +1 per upd_valid; mispred_count +1 per upd_valid with upd_mispred.
  - Both saturate at all-ones, no wrap.
  - clear_stats zeroes both and wins over a same-cycle increment.
- Reset mid-operation: asynchronous return to the reset values above. The table is rewritten by a fresh INIT sweep, so no trained state survives.

Test Plan:
1. INDEX_BITS=8: release rst_n. ready rises exactly 256 cycles later; pred_valid/upd_valid asserted during INIT produce no response and no count change. First lookup pc 0x40 -> pred_taken 0, pred_index 0x10, pred_hist 0.
2. Counter saturation, CTR_BITS=2:
   - Two taken updates to index 0x10 -> counter 01->10->11; lookup pc 0x40 with GHR 0 -> pred_taken 1.
   - Five more taken updates: counter stays 11.
   - Four not-taken updates -> 00; further not-taken updates stay 00.
3. Speculative history: with index 0x10 trained taken and GHR 0, lookup pc 0x40 -> GHR 0x01. Next lookup pc 0x40 -> pred_index 0x11, pred_hist 0x01.
4. Mispredict repair: upd_valid/upd_mispred with upd_hist 0x5A, upd_taken 1, plus a same-cycle lookup.
   - GHR becomes 0xB5.
   - Lookup response uses the pre-repair GHR.
   - branch_count +1, mispred_count +1.
5. Stats, STAT_BITS=4: 20 updates (all mispredicted) -> both counts 15. clear_stats asserted with an update -> both 0 next cycle.
6. Reset mid-run: drop rst_n during RUN.
   - ready, counts and pred_resp_valid go to 0 before the next clk edge.
   - After a fresh 256-cycle sweep, previously trained index 0x10 predicts 0.
